float_to_int: RTL and testbench

Pipelined converter from IEEE-754 single precision to signed 32-bit two's-complement integer with C cast semantics: round toward zero, saturating on overflow. It is the companion of the integer-to-float unit in the C backend's FP datapath. It serves `(int)` casts issued by the core. It has three register stages, with a valid bit carried alongside the data and a pipeline-wide enable.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_rshift.sv | 53 +++++
 rtl/float_to_int.sv | 139 +++++++++++++
 tb/tb_float_to_int.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and operand classification for the single-precision FP datapath.
// Used by the float-to-int converter and its right shifter.

package fp_pkg;

    localparam logic [7:0]  FP_BIAS          = 8'd127;
    localparam logic [7:0]  FP_INT_EXP_LIMIT = 8'd158;
    localparam logic [7:0]  FP_EXP_MAX       = 8'd255;
    localparam logic [31:0] INT32_MIN        = 32'h8000_0000;
    localparam logic [31:0] INT32_MAX        = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        ZERO,
        NAN,
        BIG,
        NORMAL
    } fp_class_e;

    // NAN must be tested before BIG since both have the maximum exponent.
    function automatic fp_class_e fp_classify(input logic [7:0] e, input logic [22:0] m);
        fp_class_e cls;
        if (e < FP_BIAS) begin
            cls = ZERO;
        end else if (e == FP_EXP_MAX && m != 23'd0) begin
            cls = NAN;
        end else if (e >= FP_INT_EXP_LIMIT) begin
            cls = BIG;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

    // Only -2^31 itself fits the integer range among the BIG operands.
    function automatic logic fp_is_int32_min(input logic s, input logic [7:0] e,
                                             input logic [22:0] m);
        return s && (e == FP_INT_EXP_LIMIT) && (m == 23'd0);
    endfunction

endpackage

// File: rtl/fp_rshift.sv
// 32-bit combinational logical right barrel shifter, five log stages.
// Bits shifted past bit 0 are discarded.

module fp_rshift (
    input  logic [31:0] din,
    input  logic [4:0]  amt,
    output logic [31:0] dout
);

    logic [31:0] lvl1;
    logic [31:0] lvl2;
    logic [31:0] lvl4;
    logic [31:0] lvl8;
    logic [31:0] lvl16;

    always_comb begin
        lvl1 = din;
        if (amt[0]) begin
            lvl1 = {1'b0, din[31:1]};
        end
    end

    always_comb begin
        lvl2 = lvl1;
        if (amt[1]) begin
            lvl2 = {2'b0, lvl1[31:2]};
        end
    end

    always_comb begin
        lvl4 = lvl2;
        if (amt[2]) begin
            lvl4 = {4'b0, lvl2[31:4]};
        end
    end

    always_comb begin
        lvl8 = lvl4;
        if (amt[3]) begin
            lvl8 = {8'b0, lvl4[31:8]};
        end
    end

    always_comb begin
        lvl16 = lvl8;
        if (amt[4]) begin
            lvl16 = {16'b0, lvl8[31:16]};
        end
    end

    assign dout = lvl16;

endmodule

// File: rtl/float_to_int.sv
// Three-stage IEEE-754 single to int32 converter: truncate toward zero, saturate on overflow.
// All stages advance together on en; valid travels beside the data.

module float_to_int
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic [31:0] fl,
    output logic        out_valid,
    output logic [31:0] res,
    output logic        ovf
);

    // ---------------------------------------------------------------- S0: unpack
    fp_class_e   in_cls;

    logic        s0_valid_q;
    logic        s0_sign_q;
    logic [7:0]  s0_exp_q;
    logic [22:0] s0_man_q;
    fp_class_e   s0_cls_q;

    assign in_cls = fp_classify(fl[30:23], fl[22:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_sign_q  <= 1'b0;
            s0_exp_q   <= 8'd0;
            s0_man_q   <= 23'd0;
            s0_cls_q   <= ZERO;
        end else if (en) begin
            s0_valid_q <= in_valid;
            s0_sign_q  <= fl[31];
            s0_exp_q   <= fl[30:23];
            s0_man_q   <= fl[22:0];
            s0_cls_q   <= in_cls;
        end
    end

    // ---------------------------------------------------------------- S1: align
    logic [7:0]  shift_full;
    logic [4:0]  shift_amt;
    logic [31:0] significand;
    logic [31:0] shifted;
    logic        exact_min;
    logic        unused_shift_hi;

    // Within NORMAL the distance is 1..31, so the low five bits carry it exactly.
    assign shift_full      = FP_INT_EXP_LIMIT - s0_exp_q;
    assign shift_amt       = shift_full[4:0];
    assign unused_shift_hi = ^shift_full[7:5];
    assign significand     = {1'b1, s0_man_q, 8'b0};
    assign exact_min       = fp_is_int32_min(s0_sign_q, s0_exp_q, s0_man_q);

    fp_rshift u_rshift (
        .din  (significand),
        .amt  (shift_amt),
        .dout (shifted)
    );

    logic        s1_valid_q;
    logic        s1_sign_q;
    logic [31:0] s1_mag_q;
    fp_class_e   s1_cls_q;
    logic        s1_exact_min_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_mag_q       <= 32'd0;
            s1_cls_q       <= ZERO;
            s1_exact_min_q <= 1'b0;
        end else if (en) begin
            s1_valid_q     <= s0_valid_q;
            s1_sign_q      <= s0_sign_q;
            s1_mag_q       <= shifted;
            s1_cls_q       <= s0_cls_q;
            s1_exact_min_q <= exact_min;
        end
    end

    // ---------------------------------------------------------------- S2: select
    logic [31:0] res_d;
    logic        ovf_d;

    always_comb begin
        res_d = 32'd0;
        ovf_d = 1'b0;
        unique case (s1_cls_q)
            ZERO: begin
                res_d = 32'd0;
                ovf_d = 1'b0;
            end
            NAN: begin
                res_d = INT32_MIN;
                ovf_d = 1'b1;
            end
            BIG: begin
                res_d = s1_sign_q ? INT32_MIN : INT32_MAX;
                ovf_d = s1_sign_q ? !s1_exact_min_q : 1'b1;
            end
            NORMAL: begin
                // Magnitude tops out at 2^31-128, so negation cannot wrap.
                res_d = s1_sign_q ? (32'd0 - s1_mag_q) : s1_mag_q;
                ovf_d = 1'b0;
            end
            default: begin
                res_d = 32'd0;
                ovf_d = 1'b0;
            end
        endcase
    end

    logic        s2_valid_q;
    logic [31:0] s2_res_q;
    logic        s2_ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= 32'd0;
            s2_ovf_q   <= 1'b0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            s2_res_q   <= res_d;
            s2_ovf_q   <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign res       = s2_res_q;
    assign ovf       = s2_ovf_q;

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed corner operands, a stalled stream,
// random traffic and an asynchronous mid-stream reset, against an arithmetic reference.

module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [31:0] fl;
    logic        out_valid;
    logic [31:0] res;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    // Expected contents in flight, index 0 = most recently accepted.
    logic        exp_v [3];
    logic [31:0] exp_f [3];
    logic [31:0] exp_r [3];
    logic        exp_o [3];

    always #5 clk = ~clk;

    float_to_int dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .fl        (fl),
        .out_valid (out_valid),
        .res       (res),
        .ovf       (ovf)
    );

    // Value of the float is 1.m * 2^(e-127); truncate, then range-check the magnitude.
    function automatic void ref_conv(input logic [31:0] f, output logic [31:0] r,
                                     output logic o);
        int     e;
        longint sig;
        longint mag;
        e   = int'(f[30:23]);
        sig = longint'({1'b1, f[22:0]});
        if (e == 255 && f[22:0] != 23'd0) begin
            r = 32'h8000_0000;
            o = 1'b1;
        end else if (e < 127) begin
            r = 32'd0;
            o = 1'b0;
        end else begin
            if (e > 180)      mag = longint'(1) << 40;
            else if (e >= 150) mag = sig << (e - 150);
            else              mag = sig >> (150 - e);
            if (!f[31]) begin
                if (mag > 64'sd2147483647) begin
                    r = 32'h7FFF_FFFF;
                    o = 1'b1;
                end else begin
                    r = mag[31:0];
                    o = 1'b0;
                end
            end else begin
                if (mag > 64'sd2147483648) begin
                    r = 32'h8000_0000;
                    o = 1'b1;
                end else begin
                    mag = -mag;
                    r   = mag[31:0];
                    o   = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic [31:0] rand_fl();
        logic [31:0] f;
        logic [7:0]  e;
        f = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: begin
                e = 8'($urandom_range(115, 165));
                f[30:23] = e;
            end
            2: begin
                e = ($urandom_range(0, 1) != 0) ? 8'd158 : 8'd157;
                f[30:23] = e;
                if ($urandom_range(0, 1) != 0) f[22:0] = 23'd0;
            end
            default: begin
                e = 8'($urandom_range(127, 131));
                f[30:23] = e;
            end
        endcase
        return f;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, want);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, want);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            exp_v[i] = 1'b0;
            exp_f[i] = 32'd0;
            exp_r[i] = 32'd0;
            exp_o[i] = 1'b0;
        end
    endtask

    // One clock: drive, advance the model on an enabled edge, then check #1 later.
    task automatic step(input logic e, input logic v, input logic [31:0] f, input string tag);
        logic [31:0] r;
        logic        o;
        en       = e;
        in_valid = v;
        fl       = f;
        @(posedge clk);
        if (e) begin
            ref_conv(f, r, o);
            for (int i = 2; i > 0; i--) begin
                exp_v[i] = exp_v[i-1];
                exp_f[i] = exp_f[i-1];
                exp_r[i] = exp_r[i-1];
                exp_o[i] = exp_o[i-1];
            end
            exp_v[0] = v;
            exp_f[0] = f;
            exp_r[0] = r;
            exp_o[0] = o;
        end
        #1;
        chk1($sformatf("%s out_valid", tag), out_valid, exp_v[2]);
        if (exp_v[2]) begin
            chk32($sformatf("%s res(fl=%08h)", tag, exp_f[2]), res, exp_r[2]);
            chk1($sformatf("%s ovf(fl=%08h)", tag, exp_f[2]), ovf, exp_o[2]);
        end
    endtask

    initial begin
        logic [31:0] directed [18];
        directed = '{32'h3F80_0000, 32'hC049_0FDB, 32'h42F6_E979,
                     32'h3F7F_FFFF, 32'h0000_0001, 32'h8000_0000, 32'hBF7F_FFFF,
                     32'h4EFF_FFFF, 32'h4F00_0000, 32'hCF00_0000, 32'hCF00_0001,
                     32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h4120_0000, 32'hC120_0000, 32'h3F00_0000, 32'hCEFF_FFFF};

        rst      = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        fl       = 32'd0;
        clear_model();
        #12;
        chk1("reset out_valid", out_valid, 1'b0);
        chk32("reset res", res, 32'd0);
        chk1("reset ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed operands back to back, then flushed.
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, directed[i], "directed");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, "flush");

        // Hand-derived expectations, independent of the reference function.
        step(1'b1, 1'b1, 32'h4EFF_FFFF, "edge_max");
        step(1'b1, 1'b0, 32'd0, "edge_max");
        step(1'b1, 1'b0, 32'd0, "edge_max");
        chk32("const 4EFFFFFF res", res, 32'h7FFF_FF80);
        chk1("const 4EFFFFFF ovf", ovf, 1'b0);
        step(1'b1, 1'b1, 32'hC049_0FDB, "edge_pi");
        step(1'b1, 1'b0, 32'd0, "edge_pi");
        step(1'b1, 1'b0, 32'd0, "edge_pi");
        chk32("const C0490FDB res", res, 32'hFFFF_FFFD);
        step(1'b1, 1'b0, 32'd0, "flush");

        // Eight back-to-back operands with a two-cycle stall in the middle.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                step(1'b0, 1'b1, 32'h4F80_0000, "stall");
                step(1'b0, 1'b0, 32'h3F80_0000, "stall");
            end
            step(1'b1, 1'b1, rand_fl(), "stream");
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, "stream_flush");

        // Random traffic with random enable and valid.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rand_fl(), "random");
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, "random_flush");

        // Asynchronous reset with three items in flight.
        step(1'b1, 1'b1, 32'h4F00_0000, "pre_rst");
        step(1'b1, 1'b1, 32'h7FC0_0000, "pre_rst");
        step(1'b1, 1'b1, 32'hFF80_0000, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst out_valid", out_valid, 1'b0);
        chk32("async_rst res", res, 32'd0);
        chk1("async_rst ovf", ovf, 1'b0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 32'h4120_0000, "post_rst");
        step(1'b1, 1'b0, 32'd0, "post_rst");
        step(1'b1, 1'b0, 32'd0, "post_rst");
        chk32("post_rst 10.0 res", res, 32'h0000_000A);
        chk1("post_rst 10.0 valid", out_valid, 1'b1);
        step(1'b1, 1'b0, 32'd0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
